// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    function automatic int bytes_of(input size_t s);
        case (s)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/shift and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  size_t                       size,
    input  logic                        unsigned_ld,
    input  logic [DATA_W-1:0]           writedata,
    input  logic [DATA_W-1:0]           rword,
    output logic [DATA_W/8-1:0]         byte_en,
    output logic [DATA_W-1:0]           store_word,
    output logic [DATA_W-1:0]           load_data
);

    localparam int NB = DATA_W / 8;

    int                nbytes;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    assign nbytes     = bytes_of(size);
    assign store_word = writedata << {lane, 3'b000};
    assign shifted    = rword >> {lane, 3'b000};

    always_comb begin
        byte_en = '0;
        for (int b = 0; b < NB; b++) begin
            byte_en[b] = (b >= int'(lane)) && (b < int'(lane) + nbytes);
        end
    end

    always_comb begin
        case (size)
            SZ_B:    sign = shifted[7];
            SZ_H:    sign = shifted[15];
            SZ_W:    sign = shifted[31];
            default: sign = shifted[DATA_W-1];
        endcase
        // Bytes above the access width become the extension; full width untouched.
        load_data = shifted;
        for (int b = 0; b < NB; b++) begin
            if (b >= nbytes) begin
                load_data[b*8 +: 8] = {8{sign & ~unsigned_ld}};
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with sub-word access, fixed latency
// busywait handshake and an error response for illegal requests.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int LW    = $clog2(NB);
    localparam int DEPTH = (2 ** ADDR_W) / NB;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    size_t             size_q;
    logic              uns_q, rd_q, wr_q, ill_q;
    logic [DATA_W-1:0] wdata_q;

    size_t             size_in;
    logic              misal, ill, access;
    logic [ADDR_W-LW-1:0] idx;
    logic [DATA_W-1:0] rword, store_word, load_data, merged;
    logic [NB-1:0]     byte_en;

    assign size_in = size_t'(size);
    assign idx     = addr_q[ADDR_W-1:LW];
    assign rword   = mem[idx];
    assign access  = (state == BUSY) && (cnt == '0);

    always_comb begin
        case (size_in)
            SZ_B:    misal = 1'b0;
            SZ_H:    misal = address[0];
            SZ_W:    misal = |address[1:0];
            default: misal = |address[2:0];
        endcase
        ill = (read & write) | misal | ((size_in == SZ_D) && (DATA_W == 32));
    end

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane        (addr_q[LW-1:0]),
        .size        (size_q),
        .unsigned_ld (uns_q),
        .writedata   (wdata_q),
        .rword       (rword),
        .byte_en     (byte_en),
        .store_word  (store_word),
        .load_data   (load_data)
    );

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            merged[b*8 +: 8] = byte_en[b] ? store_word[b*8 +: 8] : rword[b*8 +: 8];
        end
    end

    always_comb begin
        state_n  = state;
        busywait = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                busywait = read | write;
                if (read | write) state_n = BUSY;
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt == '0) state_n = DONE;
            end
            DONE: begin
                err     = ill_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (read | write)) begin
                addr_q  <= address;
                size_q  <= size_in;
                uns_q   <= unsigned_ld;
                wdata_q <= writedata;
                rd_q    <= read;
                wr_q    <= write;
                ill_q   <= ill;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access && !ill_q) begin
                if (wr_q) mem[idx] <= merged;
                if (rd_q) readdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl (DATA_W=32, LATENCY=5 plus a LATENCY=1 copy).
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        read, write, unsigned_ld;
    logic [9:0]  address;
    logic [1:0]  size;
    logic [31:0] writedata, readdata;
    logic        busywait, err;

    logic        r1, w1, u1, bw1, e1;
    logic [9:0]  a1;
    logic [1:0]  s1;
    logic [31:0] wd1, rd1;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(10), .LATENCY(5)) u_dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .size(size), .unsigned_ld(unsigned_ld),
        .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .err(err)
    );

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .read(r1), .write(w1),
        .address(a1), .size(s1), .unsigned_ld(u1),
        .writedata(wd1), .readdata(rd1),
        .busywait(bw1), .err(e1)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a busywait falling edge outside reset is one completed access.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else if (busywait) begin
            run++;
        end else if (run > 0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_completion: got rd %h err %b expected none",
                         readdata, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_rd"}, readdata, e.rd);
                chk({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
                chk({e.name, "_busy_len"}, 32'(run), 32'd6);
            end
            run = 0;
        end else begin
            chk("err_idle", {31'b0, err}, 32'd0);
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [9:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int k;
        exp_t e;
        if (rd && !wr && !exp_err) last_rd = exp_rd;
        e.rd = last_rd;
        e.err = exp_err;
        e.name = nm;
        sb.push_back(e);
        read = rd; write = wr; address = a; size = sz;
        unsigned_ld = u; writedata = wd;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (busywait && k < 20);
        if (busywait) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busywait 1 expected 0 within 20 cycles", nm);
        end
        // Hold the request through DONE, then retire it.
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic req1(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int n, k;
        r1 = rd; w1 = wr; a1 = a; s1 = 2'd2; u1 = 1'b0; wd1 = 32'h5A5A5A5A;
        #1;
        n = 0; k = 0;
        while (bw1 && k < 10) begin
            n++;
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_busy_len"}, 32'(n), 32'd2);
        chk({nm, "_err"}, {31'b0, e1}, {31'b0, exp_err});
        chk({nm, "_rd"}, rd1, exp_rd);
        @(posedge clk); #1;
        r1 = 1'b0; w1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; size = 2'd0;
        unsigned_ld = 1'b0; writedata = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; s1 = 2'd0; u1 = 1'b0; wd1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busywait", {31'b0, busywait}, 32'd0);
        chk("reset_rd", readdata, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);

        req(1, 0, 10'h010, 2'd2, 0, 32'h0, 32'h0, 0, "lw_empty");
        req(0, 1, 10'h010, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0, "sw_10");
        req(1, 0, 10'h010, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0, "lw_10");

        req(0, 1, 10'h011, 2'd0, 0, 32'h123456AA, 32'h0, 0, "sb_11");
        req(1, 0, 10'h010, 2'd2, 0, 32'h0, 32'hDEADAAEF, 0, "lw_10_b");
        req(1, 0, 10'h011, 2'd0, 0, 32'h0, 32'hFFFFFFAA, 0, "lb_11");
        req(1, 0, 10'h011, 2'd0, 1, 32'h0, 32'h000000AA, 0, "lbu_11");

        req(1, 0, 10'h012, 2'd1, 0, 32'h0, 32'hFFFFDEAD, 0, "lh_12");
        req(1, 0, 10'h012, 2'd1, 1, 32'h0, 32'h0000DEAD, 0, "lhu_12");
        req(1, 0, 10'h012, 2'd2, 0, 32'h0, 32'h0, 1, "lw_misal");
        req(0, 1, 10'h011, 2'd1, 0, 32'h00007777, 32'h0, 1, "sh_misal");
        req(1, 0, 10'h010, 2'd2, 0, 32'h0, 32'hDEADAAEF, 0, "lw_10_c");
        req(1, 0, 10'h013, 2'd0, 0, 32'h0, 32'hFFFFFFDE, 0, "lb_13");
        req(1, 0, 10'h010, 2'd0, 1, 32'h0, 32'h000000EF, 0, "lbu_10");

        req(1, 1, 10'h020, 2'd2, 0, 32'h00000055, 32'h0, 1, "rw_both");
        req(1, 0, 10'h020, 2'd2, 0, 32'h0, 32'h00000000, 0, "lw_20");
        req(1, 0, 10'h020, 2'd3, 0, 32'h0, 32'h0, 1, "ld_dword");
        req(0, 1, 10'h022, 2'd1, 0, 32'hCAFEBEEF, 32'h0, 0, "sh_22");
        req(1, 0, 10'h020, 2'd2, 0, 32'h0, 32'hBEEF0000, 0, "lw_20_b");
        req(1, 0, 10'h022, 2'd1, 0, 32'h0, 32'hFFFFBEEF, 0, "lh_22");
        req(1, 0, 10'h021, 2'd0, 0, 32'h0, 32'h00000000, 0, "lb_21");

        req1(1, 0, 10'h000, 32'h0, 0, "lat1_lw");
        req1(1, 1, 10'h004, 32'h0, 1, "lat1_rw");

        // Abort a store mid-BUSY with reset.
        read = 1'b0; write = 1'b1; address = 10'h030; size = 2'd2;
        unsigned_ld = 1'b0; writedata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; write = 1'b0;
        @(posedge clk); #1;
        chk("abort_busywait", {31'b0, busywait}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;
        chk("abort_rd_cleared", readdata, 32'd0);
        req(1, 0, 10'h030, 2'd2, 0, 32'h0, 32'h00000000, 0, "lw_30");
        req(1, 0, 10'h010, 2'd2, 0, 32'h0, 32'h00000000, 0, "lw_10_clr");

        req(0, 1, 10'h040, 2'd2, 0, 32'h11111111, 32'h0, 0, "sw_40");
        req(1, 0, 10'h040, 2'd2, 0, 32'h0, 32'h11111111, 0, "lw_40");
        req(0, 1, 10'h044, 2'd2, 0, 32'h22222222, 32'h0, 0, "sw_44");
        req(1, 0, 10'h044, 2'd2, 0, 32'h0, 32'h22222222, 0, "lw_44");
        req(1, 0, 10'h040, 2'd2, 0, 32'h0, 32'h11111111, 0, "lw_40_b");
        req(0, 1, 10'h047, 2'd0, 0, 32'h00000080, 32'h0, 0, "sb_47");
        req(1, 0, 10'h047, 2'd0, 0, 32'h0, 32'hFFFFFF80, 0, "lb_47");
        req(1, 0, 10'h044, 2'd2, 0, 32'h0, 32'h80222222, 0, "lw_44_b");

        repeat (10) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
